// File: rtl/vga_text_pkg.sv
// Shared constants and types for the text-mode VGA scanout path.
package vga_text_pkg;

  // Sum of the four segments of a raster line or frame.
  function automatic int seg_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  // Totals and counter widths for the default 640x480 timing.
  localparam int H_TOTAL = seg_total(640, 16, 96, 48);
  localparam int V_TOTAL = seg_total(480, 10, 2, 33);
  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);

  // Text buffer word layout: [7:0] character, [11:8] page.
  localparam int TEXT_W   = 12;
  localparam int ADDR_W   = 12;
  localparam int CHAR_LSB = 0;
  localparam int CHAR_W   = 8;
  localparam int PAGE_LSB = 8;
  localparam int PAGE_W   = 4;

  // Cycles from counter state to font ROM pixel.
  localparam int SCAN_LAT = 3;

  // Raw raster flags; sync flags are "inside the sync window", not levels.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic first;
  } raster_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw sync, active and first-pixel flags.
module vga_timing
  import vga_text_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HW        = $clog2(seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK)),
  parameter int VW        = $clog2(seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          line_end,
  output logic          frame_end,
  output raster_t       raw
);

  localparam int HT = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int VT = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  assign line_end  = (h == HW'(HT - 1));
  assign frame_end = line_end && (v == VW'(VT - 1));

  // Raw flags decoded straight from the current counter values.
  always_comb begin
    raw.hsync  = (h >= HW'(H_VISIBLE + H_FRONT)) && (h < HW'(H_VISIBLE + H_FRONT + H_SYNC));
    raw.vsync  = (v >= VW'(V_VISIBLE + V_FRONT)) && (v < VW'(V_VISIBLE + V_FRONT + V_SYNC));
    raw.active = (h < HW'(H_VISIBLE)) && (v < VW'(V_VISIBLE));
    raw.first  = (h == '0) && (v == '0);
  end

  // Advance h every enabled cycle; v steps at line end and both wrap together at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (line_end) begin
        h <= '0;
        v <= frame_end ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_text_scanout.sv
// Text-mode scanout: raster timing, multiplier-free cell addressing and
// alignment of glyph position and sync/blank with the font ROM pixel.
module vga_text_scanout
  import vga_text_pkg::*;
#(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   FONT_W    = 8,
  parameter int   FONT_H    = 16,
  parameter int   COLS      = 80,
  parameter int   ROWS      = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic [ADDR_W-1:0]         text_addr,
  output logic                      text_re,
  input  logic [TEXT_W-1:0]         text_data,
  output logic                      font_en,
  output logic [CHAR_W-1:0]         font_char,
  output logic [PAGE_W-1:0]         font_page,
  output logic [$clog2(FONT_W)-1:0] font_horiz,
  output logic [$clog2(FONT_H)-1:0] font_vert,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      blank_n,
  output logic                      frame_start
);

  localparam int HT  = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int VT  = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int FWB = $clog2(FONT_W);
  localparam int FHB = $clog2(FONT_H);
  // Flag stages ahead of the output registers.
  localparam int DLY = SCAN_LAT - 1;

  // The grid must tile the visible area exactly with power-of-two glyphs.
  if ((COLS * FONT_W != H_VISIBLE) || (ROWS * FONT_H != V_VISIBLE) ||
      ((1 << FWB) != FONT_W) || ((1 << FHB) != FONT_H)) begin : g_bad_geometry
    $error("vga_text_scanout: inconsistent text grid geometry");
  end

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [VW-1:0]     v_next;
  logic              line_end;
  logic              frame_end;
  raster_t           raw;
  logic [ADDR_W-1:0] row_base;
  logic [FWB-1:0]    horiz_p1;
  logic [FHB-1:0]    vert_p1;
  raster_t           ras_pipe [DLY];

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .HW        (HW),
    .VW        (VW)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .h         (h),
    .v         (v),
    .line_end  (line_end),
    .frame_end (frame_end),
    .raw       (raw)
  );

  assign v_next    = v + VW'(1);
  assign text_re   = en;
  assign font_en   = en;
  assign font_char = text_data[CHAR_LSB +: CHAR_W];
  assign font_page = text_data[PAGE_LSB +: PAGE_W];

  // Row base steps by COLS when the next line starts a new visible glyph row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
    end else if (en && line_end) begin
      if (frame_end) begin
        row_base <= '0;
      end else if ((v_next[FHB-1:0] == '0) && (v_next < VW'(V_VISIBLE))) begin
        row_base <= row_base + ADDR_W'(COLS);
      end
    end
  end

  // Stage T -> T+1: cell address; it holds its last value outside the active area.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_addr <= '0;
    end else if (en && raw.active) begin
      text_addr <= row_base + ADDR_W'(h[HW-1:FWB]);
    end
  end

  // Stage T -> T+1 -> T+2: glyph position meets the returning buffer word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      horiz_p1   <= '0;
      vert_p1    <= '0;
      font_horiz <= '0;
      font_vert  <= '0;
    end else if (en) begin
      horiz_p1   <= h[FWB-1:0];
      vert_p1    <= v[FHB-1:0];
      font_horiz <= horiz_p1;
      font_vert  <= vert_p1;
    end
  end

  // Stages T+1..T+2: raw raster flags travel alongside the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) ras_pipe[i] <= '0;
    end else if (en) begin
      ras_pipe[0] <= raw;
      for (int i = 1; i < DLY; i++) ras_pipe[i] <= ras_pipe[i-1];
    end
  end

  // Stage T+3: registered sync levels and blanking aligned with the font pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hsync       <= ras_pipe[DLY-1].hsync ? SYNC_POL : ~SYNC_POL;
      vsync       <= ras_pipe[DLY-1].vsync ? SYNC_POL : ~SYNC_POL;
      blank_n     <= ras_pipe[DLY-1].active;
      frame_start <= ras_pipe[DLY-1].first;
    end
  end

endmodule

// File: tb/tb_vga_text_scanout.sv
// Scoreboard bench for vga_text_scanout on a reduced raster (48x39 total).
module tb_vga_text_scanout;

  localparam int   HV = 32, HF = 4, HS = 8, HB = 4;
  localparam int   VV = 32, VF = 2, VS = 2, VB = 3;
  localparam int   FW = 8, FH = 16, COLS = 4, ROWS = 2;
  localparam logic POL = 1'b0;
  localparam int   HT = HV + HF + HS + HB;
  localparam int   VT = VV + VF + VS + VB;
  localparam int   FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [11:0] text_addr;
  logic        text_re;
  logic [11:0] text_data;
  logic        font_en;
  logic [7:0]  font_char;
  logic [3:0]  font_page;
  logic [2:0]  font_horiz;
  logic [3:0]  font_vert;
  logic        hsync, vsync, blank_n, frame_start;

  vga_text_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL), .FONT_W(FW), .FONT_H(FH), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .text_addr(text_addr), .text_re(text_re), .text_data(text_data),
    .font_en(font_en), .font_char(font_char), .font_page(font_page),
    .font_horiz(font_horiz), .font_vert(font_vert),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Text buffer: synchronous read with one enabled cycle of latency.
  logic [11:0] mem [4096];
  always @(posedge clk) if (text_re) text_data <= mem[text_addr];

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  chr;
    logic [3:0]  page;
    logic [2:0]  horiz;
    logic [3:0]  vert;
    logic        hs, vs, bn, fs;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        last_exp;
  bit          last_chk;
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned e;
  logic [11:0] a_cur, a_prev;

  function automatic obs_t reset_obs();
    obs_t o = '0;
    o.hs = ~POL;
    o.vs = ~POL;
    return o;
  endfunction

  function automatic obs_t actual();
    obs_t o;
    o.addr = text_addr; o.chr = font_char; o.page = font_page;
    o.horiz = font_horiz; o.vert = font_vert;
    o.hs = hsync; o.vs = vsync; o.bn = blank_n; o.fs = frame_start;
    return o;
  endfunction

  // Raster position of the p-th scanned pixel since reset.
  function automatic void pix(input int unsigned p, output int h, output int v);
    h = int'(p % HT);
    v = int'((p / HT) % VT);
  endfunction

  task automatic reset_model();
    e = 0;
    a_cur = '0;
    a_prev = '0;
  endtask

  // Expected outputs after the next enabled edge, straight from the raster rules.
  task automatic model_step();
    obs_t o;
    int h, v;
    logic [11:0] word;
    o = reset_obs();
    e++;
    pix(e - 1, h, v);
    a_prev = a_cur;
    if (h < HV && v < VV) a_cur = 12'((v / FH) * COLS + h / FW);
    o.addr = a_cur;
    word = mem[a_prev];
    o.chr = word[7:0];
    o.page = word[11:8];
    if (e >= 2) begin
      pix(e - 2, h, v);
      o.horiz = 3'(h % FW);
      o.vert = 4'(v % FH);
    end
    if (e >= 3) begin
      pix(e - 3, h, v);
      o.hs = (h >= HV + HF && h < HV + HF + HS) ? POL : ~POL;
      o.vs = (v >= VV + VF && v < VV + VF + VS) ? POL : ~POL;
      o.bn = (h < HV && v < VV);
      o.fs = (h == 0 && v == 0);
    end
    exp_q.push_back(o);
  endtask

  task automatic check(input obs_t a, input obs_t x, input bit chk_font, input string tag);
    bit ok;
    n_chk++;
    ok = (a.addr == x.addr) && (a.horiz == x.horiz) && (a.vert == x.vert) &&
         (a.hs == x.hs) && (a.vs == x.vs) && (a.bn == x.bn) && (a.fs == x.fs) &&
         (!chk_font || (a.chr == x.chr && a.page == x.page));
    if (ok) n_pass++;
    else $display("FAIL %s e=%0d got addr=%0d chr=%h pg=%h hv=%0d/%0d hs=%b vs=%b bn=%b fs=%b want addr=%0d chr=%h pg=%h hv=%0d/%0d hs=%b vs=%b bn=%b fs=%b",
                  tag, e, a.addr, a.chr, a.page, a.horiz, a.vert, a.hs, a.vs, a.bn, a.fs,
                  x.addr, x.chr, x.page, x.horiz, x.vert, x.hs, x.vs, x.bn, x.fs);
  endtask

  // Monitor: compare on every edge and on reset assertion.
  initial begin
    logic en_s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        check(actual(), reset_obs(), 1'b0, "reset");
        last_exp = reset_obs();
        last_chk = 1'b0;
      end else begin
        en_s = en;
        #1;
        n_chk++;
        if (text_re === en_s && font_en === en_s) n_pass++;
        else $display("FAIL enables got re=%b fe=%b want %b", text_re, font_en, en_s);
        if (en_s) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL underflow got output with no expectation want queued entry");
          end else begin
            last_exp = exp_q.pop_front();
            last_chk = 1'b1;
            check(actual(), last_exp, 1'b1, "scan");
          end
        end else begin
          check(actual(), last_exp, last_chk, "hold");
        end
      end
    end
  end

  // Drive one cycle at a negedge; queue the expectation if the coming edge is enabled.
  task automatic cycle(input logic en_v);
    en = en_v;
    if (en_v && rst_n) model_step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    reset_model();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Continuous scan over two full frames plus a bit.
    repeat (2 * FRAME + 200) cycle(1'b1);
    // Enable one cycle in four for a frame.
    for (int i = 0; i < 4 * FRAME; i++) cycle(i % 4 == 0);
    // Random enable pattern.
    repeat (3000) cycle($urandom_range(0, 2) != 0);

    // Mid-frame reset at (h=20, v=10).
    while ((e % FRAME) != 10 * HT + 20) cycle(1'b1);
    rst_n = 1'b0;
    reset_model();
    repeat (3) cycle(1'b1);
    rst_n = 1'b1;
    repeat (2 * FRAME + 50) cycle($urandom_range(0, 3) != 0);

    en = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
